// File: rtl/mem_access_pkg.sv
// Shared types and constants for mem_access_unit and its byte-lane helper.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SZ_WORD    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_BYTE    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_e;

  // Legal bounds of the memory read latency; the counter is 3 bits wide.
  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 7;

endpackage

// File: rtl/byte_lane_merge.sv
// Big-endian byte/half lane handling: load extract with sign/zero extension,
// and store merge of new right-justified data into an old word.
module byte_lane_merge
  import mem_access_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  offset,
  input  size_e       size,
  input  logic        sign_ext,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = old_word[31:24];
      2'd1:    byte_sel = old_word[23:16];
      2'd2:    byte_sel = old_word[15:8];
      default: byte_sel = old_word[7:0];
    endcase
    // Halves use offset[1] alone, so a misaligned half silently truncates.
    half_sel = offset[1] ? old_word[15:0] : old_word[31:16];
  end

  always_comb begin
    load_data  = old_word;
    store_word = old_word;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
        case (offset)
          2'd0:    store_word[31:24] = new_data[7:0];
          2'd1:    store_word[23:16] = new_data[7:0];
          2'd2:    store_word[15:8]  = new_data[7:0];
          default: store_word[7:0]   = new_data[7:0];
        endcase
      end
      SZ_HALF: begin
        load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
        if (offset[1]) store_word[15:0]  = new_data[15:0];
        else           store_word[31:16] = new_data[15:0];
      end
      default: begin
        load_data  = old_word;
        store_word = new_data;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Byte-addressed load/store responder over a word-wide synchronous memory.
// MEM_ACCESS_ALIGN_CHECK_EN enables alignment/size error detection.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                                (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
  localparam logic [2:0]  CNT_INIT = 3'(LAT - 1);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic        sign_q, sign_d;
  size_e       size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] maddr_q, maddr_d;
  logic [31:0] mwdata_q, mwdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] ld_data;
  logic [31:0] st_word;
  size_e       req_size_n;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  logic err_q, err_d;
  logic req_err;

  always_comb begin
    req_size_n = size_e'(req_size);
    req_err    = (req_size == SZ_ILLEGAL) ||
                 ((req_size == SZ_HALF) && req_addr[0]) ||
                 ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  end
`else
  always_comb begin
    req_size_n = (req_size == SZ_ILLEGAL) ? SZ_WORD : size_e'(req_size);
  end
`endif

  // The lane helper always sees live memory data; results are captured on
  // the last READ cycle (load result or merged store word).
  byte_lane_merge u_lanes (
    .old_word   (mem_rdata),
    .new_data   (wdata_q),
    .offset     (off_q),
    .size       (size_q),
    .sign_ext   (sign_q),
    .load_data  (ld_data),
    .store_word (st_word)
  );

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    sign_d   = sign_q;
    size_d   = size_q;
    off_d    = off_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    rdata_d  = rdata_q;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          sign_d  = req_signed;
          size_d  = req_size_n;
          off_d   = req_addr[1:0];
          wdata_d = req_wdata;
          cnt_d   = CNT_INIT;
          rdata_d = '0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
          err_d   = req_err;
          if (req_err) begin
            state_d = RESP;
          end else
`endif
          begin
            maddr_d = {req_addr[31:2], 2'b00};
            if (req_we && (req_size_n == SZ_WORD)) begin
              mwdata_d = req_wdata;
              state_d  = WRITE;
            end else begin
              state_d  = READ;
            end
          end
        end
      end
      READ: begin
        if (cnt_q == 3'd0) begin
          if (we_q) begin
            mwdata_d = st_word;
            state_d  = WRITE;
          end else begin
            rdata_d  = ld_data;
            state_d  = RESP;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      sign_q   <= 1'b0;
      size_q   <= SZ_WORD;
      off_q    <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      rdata_q  <= '0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      sign_q   <= sign_d;
      size_q   <= size_d;
      off_q    <= off_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      rdata_q  <= rdata_d;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign mem_wr    = (state_q == WRITE);
  assign mem_addr  = maddr_q;
  assign mem_wdata = mwdata_q;
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign rsp_err   = rsp_valid & err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: instance 0 has RD_LAT=1, instance 1 RD_LAT=3.
module tb_mem_access_unit;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [1:0]  req_size  [2];
  logic        req_signed[2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic [31:0] mem_addr  [2];
  logic        mem_wr    [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];

  logic [31:0] mem [2][64];
  int          wr_cnt [2] = '{0, 0};
  logic [31:0] wr_addr[2];
  logic [31:0] wr_data[2];

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       nm;
    int unsigned d;
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] init;
    bit          busy;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          wr;
    logic [31:0] wa;
    logic [31:0] wd;
    bit          maddr_hold;
  } vec_t;

  typedef struct {
    int          lat;
    logic [31:0] rdata;
    logic        err;
    logic        pulse_ok;
    int          wr;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [31:0] maddr;
    logic [31:0] maddr_pre;
    logic [31:0] mword;
  } obs_t;

  vec_t sb[$];

  always #5 clk = ~clk;

  mem_access_unit #(.RD_LAT(1)) u_lat1 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_size(req_size[0]), .req_signed(req_signed[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .mem_addr(mem_addr[0]), .mem_wr(mem_wr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  mem_access_unit #(.RD_LAT(3)) u_lat3 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_size(req_size[1]), .req_signed(req_signed[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .mem_addr(mem_addr[1]), .mem_wr(mem_wr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  assign mem_rdata[0] = mem[0][mem_addr[0][7:2]];
  assign mem_rdata[1] = mem[1][mem_addr[1][7:2]];

  // Memory write port and write monitor, sampled mid-cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_wr[d]) begin
        mem[d][mem_addr[d][7:2]] <= mem_wdata[d];
        wr_cnt[d]  <= wr_cnt[d] + 1;
        wr_addr[d] <= mem_addr[d];
        wr_data[d] <= mem_wdata[d];
      end
    end
  end

  function automatic vec_t mk(string nm, int unsigned d, logic we, logic [1:0] size,
                              logic sgn, logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] init, bit busy, int lat, logic [31:0] rdata,
                              logic err, int wr, logic [31:0] wa, logic [31:0] wd,
                              bit maddr_hold);
    vec_t v;
    v.nm = nm; v.d = d; v.we = we; v.size = size; v.sgn = sgn; v.addr = addr;
    v.wdata = wdata; v.init = init; v.busy = busy; v.lat = lat; v.rdata = rdata;
    v.err = err; v.wr = wr; v.wa = wa; v.wd = wd; v.maddr_hold = maddr_hold;
    return v;
  endfunction

  task automatic do_req(input vec_t v, output obs_t o);
    int base;
    int n;
    base = wr_cnt[v.d];
    mem[v.d][v.addr[7:2]] = v.init;
    o.maddr_pre = mem_addr[v.d];
    @(negedge clk);
    req_valid[v.d]  = 1'b1;
    req_we[v.d]     = v.we;
    req_size[v.d]   = v.size;
    req_signed[v.d] = v.sgn;
    req_addr[v.d]   = v.addr;
    req_wdata[v.d]  = v.wdata;
    @(posedge clk); #1;
    req_valid[v.d] = 1'b0;
    n = 1;
    if (v.busy) begin
      req_valid[v.d] = 1'b1;
      req_we[v.d]    = 1'b1;
      req_size[v.d]  = 2'b00;
      req_addr[v.d]  = 32'h0000_003C;
      req_wdata[v.d] = 32'h7777_7777;
    end
    while (!rsp_valid[v.d] && n < 40) begin
      @(posedge clk); #1;
      req_valid[v.d] = 1'b0;
      n++;
    end
    req_valid[v.d] = 1'b0;
    o.lat   = rsp_valid[v.d] ? n : -1;
    o.rdata = rsp_rdata[v.d];
    o.err   = rsp_err[v.d];
    @(posedge clk); #1;
    o.pulse_ok = !rsp_valid[v.d] && req_ready[v.d];
    @(negedge clk); #1;
    o.wr    = wr_cnt[v.d] - base;
    o.wa    = wr_addr[v.d];
    o.wd    = wr_data[v.d];
    o.maddr = mem_addr[v.d];
    o.mword = mem[v.d][v.addr[7:2]];
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 || rsp_err[d] !== 1'b0 ||
          mem_wr[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_ctl[%0d]: got ready=%b valid=%b err=%b wr=%b expected 1 0 0 0",
                 d, req_ready[d], rsp_valid[d], rsp_err[d], mem_wr[d]);
      end
      checks++;
      if (rsp_rdata[d] !== 32'h0 || mem_addr[d] !== 32'h0 || mem_wdata[d] !== 32'h0) begin
        failures++;
        $display("FAIL reset_data[%0d]: got rdata=%h addr=%h wdata=%h expected all 0",
                 d, rsp_rdata[d], mem_addr[d], mem_wdata[d]);
      end
    end
  endtask

  task automatic test_loads();
    vec_t v[7];
    vec_t e;
    obs_t o;
    v[0] = mk("ld_word",   0, 0, 2'b00, 0, 32'h10, 0, 32'h8899_AABB, 0, 2, 32'h8899_AABB, 0, 0, 0, 0, 0);
    v[1] = mk("ld_sbyte",  0, 0, 2'b10, 1, 32'h13, 0, 32'h1122_33F0, 0, 2, 32'hFFFF_FFF0, 0, 0, 0, 0, 0);
    v[2] = mk("ld_ubyte",  0, 0, 2'b10, 0, 32'h13, 0, 32'h1122_33F0, 0, 2, 32'h0000_00F0, 0, 0, 0, 0, 0);
    v[3] = mk("ld_shalf_lo", 0, 0, 2'b01, 1, 32'h16, 0, 32'h8001_7FFF, 0, 2, 32'h0000_7FFF, 0, 0, 0, 0, 0);
    v[4] = mk("ld_shalf_hi", 0, 0, 2'b01, 1, 32'h14, 0, 32'h8001_7FFF, 0, 2, 32'hFFFF_8001, 0, 0, 0, 0, 0);
    v[5] = mk("ld_word_lat3", 1, 0, 2'b00, 0, 32'h1C, 0, 32'hDEAD_BEEF, 0, 4, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    v[6] = mk("ld_ubyte_lat3", 1, 0, 2'b10, 0, 32'h1E, 0, 32'hCAFE_BABE, 0, 4, 32'h0000_00BA, 0, 0, 0, 0, 0);
    foreach (v[i]) begin
      sb.push_back(v[i]);
      do_req(v[i], o);
      e = sb.pop_front();
      checks++;
      if (o.lat !== e.lat) begin failures++; $display("FAIL %s latency: got %0d expected %0d", e.nm, o.lat, e.lat); end
      checks++;
      if (o.rdata !== e.rdata) begin failures++; $display("FAIL %s rdata: got %h expected %h", e.nm, o.rdata, e.rdata); end
      checks++;
      if (o.err !== e.err) begin failures++; $display("FAIL %s err: got %b expected %b", e.nm, o.err, e.err); end
      checks++;
      if (o.wr !== e.wr) begin failures++; $display("FAIL %s writes: got %0d expected %0d", e.nm, o.wr, e.wr); end
      checks++;
      if (o.maddr !== {e.addr[31:2], 2'b00}) begin
        failures++; $display("FAIL %s mem_addr: got %h expected %h", e.nm, o.maddr, {e.addr[31:2], 2'b00});
      end
      checks++;
      if (o.pulse_ok !== 1'b1) begin failures++; $display("FAIL %s rsp_pulse: got %b expected 1", e.nm, o.pulse_ok); end
    end
  endtask

  task automatic test_stores();
    vec_t v[5];
    vec_t e;
    obs_t o;
    v[0] = mk("st_half",     0, 1, 2'b01, 0, 32'h22, 32'h0000_BEEF, 32'h1234_5678, 0, 3, 0, 0, 1, 32'h20, 32'h1234_BEEF, 0);
    v[1] = mk("st_word",     0, 1, 2'b00, 0, 32'h30, 32'h0BAD_F00D, 32'hFFFF_FFFF, 0, 2, 0, 0, 1, 32'h30, 32'h0BAD_F00D, 0);
    v[2] = mk("st_byte3",    0, 1, 2'b10, 0, 32'h2B, 32'h0000_00CC, 32'h1122_3344, 0, 3, 0, 0, 1, 32'h28, 32'h1122_33CC, 0);
    v[3] = mk("st_byte_lat3", 1, 1, 2'b10, 0, 32'h01, 32'h0000_00AB, 32'h0000_0000, 1, 5, 0, 0, 1, 32'h00, 32'h00AB_0000, 0);
    v[4] = mk("st_half_lat3", 1, 1, 2'b01, 0, 32'h24, 32'hFFFF_1234, 32'h0000_0000, 0, 5, 0, 0, 1, 32'h24, 32'h1234_0000, 0);
    foreach (v[i]) begin
      sb.push_back(v[i]);
      do_req(v[i], o);
      e = sb.pop_front();
      checks++;
      if (o.lat !== e.lat) begin failures++; $display("FAIL %s latency: got %0d expected %0d", e.nm, o.lat, e.lat); end
      checks++;
      if (o.rdata !== 32'h0 || o.err !== 1'b0) begin
        failures++; $display("FAIL %s rsp: got rdata=%h err=%b expected 0 0", e.nm, o.rdata, o.err);
      end
      checks++;
      if (o.wr !== e.wr) begin failures++; $display("FAIL %s writes: got %0d expected %0d", e.nm, o.wr, e.wr); end
      checks++;
      if (o.wa !== e.wa || o.wd !== e.wd) begin
        failures++; $display("FAIL %s write: got %h/%h expected %h/%h", e.nm, o.wa, o.wd, e.wa, e.wd);
      end
      checks++;
      if (o.mword !== e.wd) begin failures++; $display("FAIL %s mem_word: got %h expected %h", e.nm, o.mword, e.wd); end
      checks++;
      if (o.pulse_ok !== 1'b1) begin failures++; $display("FAIL %s rsp_pulse: got %b expected 1", e.nm, o.pulse_ok); end
    end
  endtask

  task automatic test_errors();
    vec_t v[5];
    vec_t e;
    obs_t o;
    logic [31:0] exp_maddr;
    logic [31:0] exp_mword;
    v[0] = mk("err_ld_w06", 0, 0, 2'b00, 0, 32'h06, 0, 32'h0102_0304, 0,
              ALIGN_EN ? 1 : 2, ALIGN_EN ? 32'h0 : 32'h0102_0304, ALIGN_EN, 0, 0, 0, ALIGN_EN);
    v[1] = mk("err_ld_h09", 0, 0, 2'b01, 0, 32'h09, 0, 32'hCAFE_F00D, 0,
              ALIGN_EN ? 1 : 2, ALIGN_EN ? 32'h0 : 32'h0000_CAFE, ALIGN_EN, 0, 0, 0, ALIGN_EN);
    v[2] = mk("err_sz11", 0, 0, 2'b11, 1, 32'h0C, 0, 32'h5566_7788, 0,
              ALIGN_EN ? 1 : 2, ALIGN_EN ? 32'h0 : 32'h5566_7788, ALIGN_EN, 0, 0, 0, ALIGN_EN);
    v[3] = mk("err_st_w06", 0, 1, 2'b00, 0, 32'h06, 32'h5A5A_5A5A, 32'h0102_0304, 0,
              ALIGN_EN ? 1 : 2, 0, ALIGN_EN, ALIGN_EN ? 0 : 1, 32'h04, 32'h5A5A_5A5A, ALIGN_EN);
    v[4] = mk("err_st_h23", 0, 1, 2'b01, 0, 32'h23, 32'h0000_ABCD, 32'h1234_5678, 0,
              ALIGN_EN ? 1 : 3, 0, ALIGN_EN, ALIGN_EN ? 0 : 1, 32'h20, 32'h1234_ABCD, ALIGN_EN);
    foreach (v[i]) begin
      sb.push_back(v[i]);
      do_req(v[i], o);
      e = sb.pop_front();
      checks++;
      if (o.lat !== e.lat) begin failures++; $display("FAIL %s latency: got %0d expected %0d", e.nm, o.lat, e.lat); end
      checks++;
      if (o.rdata !== e.rdata) begin failures++; $display("FAIL %s rdata: got %h expected %h", e.nm, o.rdata, e.rdata); end
      checks++;
      if (o.err !== e.err) begin failures++; $display("FAIL %s err: got %b expected %b", e.nm, o.err, e.err); end
      checks++;
      if (o.wr !== e.wr) begin failures++; $display("FAIL %s writes: got %0d expected %0d", e.nm, o.wr, e.wr); end
      exp_maddr = e.maddr_hold ? o.maddr_pre : {e.addr[31:2], 2'b00};
      checks++;
      if (o.maddr !== exp_maddr) begin failures++; $display("FAIL %s mem_addr: got %h expected %h", e.nm, o.maddr, exp_maddr); end
      exp_mword = (e.wr != 0) ? e.wd : e.init;
      checks++;
      if (o.mword !== exp_mword) begin failures++; $display("FAIL %s mem_word: got %h expected %h", e.nm, o.mword, exp_mword); end
    end
  endtask

  task automatic test_reset_mid_write();
    int base;
    base = wr_cnt[0];
    mem[0][9] = 32'hAAAA_BBBB;
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_size[0] = 2'b01;
    req_signed[0] = 1'b0; req_addr[0] = 32'h26; req_wdata[0] = 32'h0000_1111;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mem_wr[0] !== 1'b1) begin failures++; $display("FAIL rst_mid pre_wr: got %b expected 1", mem_wr[0]); end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (mem_wr[0] !== 1'b0 || req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid async: got wr=%b ready=%b valid=%b expected 0 1 0", mem_wr[0], req_ready[0], rsp_valid[0]);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (wr_cnt[0] !== base || mem[0][9] !== 32'hAAAA_BBBB) begin
      failures++;
      $display("FAIL rst_mid no_write: got writes=%0d word=%h expected 0 aaaabbbb", wr_cnt[0] - base, mem[0][9]);
    end
    checks++;
    if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
      failures++; $display("FAIL rst_mid idle: got valid=%b ready=%b expected 0 1", rsp_valid[0], req_ready[0]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = 2'b00;
      req_signed[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0;
      for (int w = 0; w < 64; w++) mem[d][w] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk); #1;
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-side responder for the multicycle datapath's address/data interface.
- Accepts one byte-addressed access request from the control FSM: load/store, word/half/byte, signed/unsigned.
- Drives the word-wide synchronous memory and returns the aligned, extended load data.
- Sub-word stores are done as read-modify-write, so the memory needs only a word write port.

Parameters:
- RD_LAT, 1, memory read latency in cycles from mem_addr valid to mem_rdata valid (legal range 1..7).

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle and able to accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 word, 01 half, 10 byte, 11 illegal
- req_signed  in  1  sign-extend sub-word loads
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified for sub-word stores
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  load result, valid with rsp_valid; 0 for stores and errors
- rsp_err  out  1  alignment/size error, valid with rsp_valid
- mem_addr  out  32  word address to memory, low 2 bits always 00
- mem_wr  out  1  memory write strobe
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data

Behaviour:
- Byte order: big-endian. Byte offset 0 maps to bits [31:24]; half offset 0 maps to [31:16].
- Reset values: req_ready 1; rsp_valid, rsp_err, mem_wr 0; rsp_rdata, mem_addr, mem_wdata 0. State is IDLE.
- Handshake:
  - Accept on req_valid && req_ready. Request fields are registered at accept.
  - req_ready is 1 only in IDLE. req_valid outside IDLE is ignored.
  - No response backpressure: rsp_valid is asserted for exactly 1 cycle.
- States: IDLE, READ, WRITE, RESP.
- IDLE, on accept:
  - Error (see below) -> RESP.
  - Word store -> WRITE.
  - All loads and sub-word stores -> READ.
- READ:
  - mem_addr = {addr[31:2],2'b00}, mem_wr = 0.
  - A 3-bit counter runs RD_LAT cycles; mem_rdata is captured in the last cycle.
  - Load -> RESP. Sub-word store -> WRITE.
- WRITE:
  - mem_wr = 1 for exactly 1 cycle, mem_addr held.
  - mem_wdata is req_wdata for a word store, or the captured word with the addressed lane replaced by req_wdata[7:0] / [15:0].
  - -> RESP.
- RESP:
  - rsp_valid = 1.
  - For loads, rsp_rdata is the addressed lane, sign- or zero-extended per req_signed.
  - -> IDLE. req_ready returns next cycle.
- Latency from the accept cycle to rsp_valid:
  - Load: RD_LAT+1 cycles.
  - Word store: 2 cycles.
  - Sub-word store: RD_LAT+2 cycles.
  - Error: 1 cycle.
- Errors:
  - Conditions: size 11; half with addr[0]=1; word with addr[1:0]!=00.
  - No memory access (mem_wr stays 0). rsp_err=1, rsp_rdata=0.
- Reset mid-operation: state returns to IDLE and mem_wr drops immediately (async). No partial write completes after reset is deasserted.
- mem_wr is never asserted outside WRITE. mem_addr holds its last value in IDLE.

Optional Feature:
- Macro: MEM_ACCESS_ALIGN_CHECK_EN.
- Defined: error detection as above.
- Undefined:
  - rsp_err is tied to 0.
  - Misaligned addresses are silently truncated: half uses addr[1] only, word ignores addr[1:0].
  - Size 11 is treated as word.
  - The error path is removed from the FSM.

Decomposition:
- Package mem_access_pkg holds:
  - Size encodings: SZ_WORD, SZ_HALF, SZ_BYTE.
  - State enum.
  - RD_LAT bounds constant.
- One natural sub-module, byte_lane_merge. It is combinational and contains:
  - Load extract/extend (word, offset, size, signed -> result).
  - Store merge (old word, new data, offset, size -> merged word).
- The FSM, counter and registers stay in mem_access_unit.

Test Plan:
- Word load, RD_LAT=1, addr 0x0000_0010, mem word 0x8899_AABB -> mem_addr 0x10, rsp_valid 2 cycles after accept, rsp_rdata 0x8899_AABB, rsp_err 0.
- Signed byte load, addr 0x13, mem 0x1122_33F0 -> rsp_rdata 0xFFFF_FFF0; same access unsigned -> 0x0000_00F0.
- Half store, addr 0x22, wdata 0x0000_BEEF, old word 0x1234_5678 -> one READ, then exactly one mem_wr pulse with mem_addr 0x20, mem_wdata 0x1234_BEEF.
- Misaligned word load, addr 0x06, macro defined -> rsp_valid next cycle, rsp_err 1, rsp_rdata 0, mem_wr never 1. Macro undefined -> access to 0x04, rsp_err 0.
- RD_LAT=3 byte store, addr 0x01, wdata 0xAB, old 0x0000_0000 -> mem_wdata 0x00AB_0000, rsp_valid 5 cycles after accept. req_valid pulses during the busy period are ignored.
- reset_n low during WRITE of a half store -> mem_wr falls immediately, req_ready 1, rsp_valid 0. No write occurs after reset is released.
